// File: rtl/ifu_imem_responder_if.sv
// IFetch REQ/RSP channel between the fetch unit (master) and the instruction-memory responder (slave).
interface ifu_imem_responder_if #(
    parameter int unsigned PC_SIZE    = 32,
    parameter int unsigned INSTR_SIZE = 32
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic [PC_SIZE-1:0]    req_pc;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [INSTR_SIZE-1:0] rsp_instr;
    logic                  rsp_err;

    modport master (
        output req_valid, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_err
    );

    modport slave (
        input  req_valid, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_err
    );
endinterface

// File: rtl/ifu_imem_responder.sv
// Responder end of the IFetch channel: one outstanding fetch, optional wait cycles,
// one synchronous SRAM read, fault flag for misaligned or out-of-window addresses.
module ifu_imem_responder #(
    parameter int unsigned        PC_SIZE    = 32,
    parameter int unsigned        INSTR_SIZE = 32,
    parameter int unsigned        LATENCY    = 0,
    parameter logic [PC_SIZE-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned        DEPTH_LOG2 = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    ifu_imem_responder_if.slave   ifu,
    output logic                  mem_en,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    input  logic [INSTR_SIZE-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_MEM  = 3'd2,
        S_DATA = 3'd3,
        S_RESP = 3'd4
    } state_e;

    localparam logic [3:0]     LAT_C  = 4'(LATENCY);
    localparam logic [PC_SIZE:0] ONE_C  = {{PC_SIZE{1'b0}}, 1'b1};
    localparam logic [PC_SIZE:0] SPAN_C = ONE_C << (DEPTH_LOG2 + 2);

    state_e                 state_q;
    logic [3:0]             cnt_q;
    logic [DEPTH_LOG2-1:0]  addr_q;
    logic                   rsp_valid_q;
    logic [INSTR_SIZE-1:0]  instr_q;
    logic                   err_q;
    logic                   mem_en_q;
    logic [DEPTH_LOG2-1:0]  mem_addr_q;

    logic [PC_SIZE-1:0]     offset_s;
    logic                   err_s;
    logic [DEPTH_LOG2-1:0]  word_s;
    logic                   req_ready_s;
    logic                   accept_s;

    // Unsigned offset into the SRAM window; a wrapped offset from pc < BASE is caught separately.
    assign offset_s = ifu.req_pc - BASE_ADDR;
    assign word_s   = offset_s[DEPTH_LOG2+1:2];
    assign err_s    = (ifu.req_pc[1:0] != 2'b00)
                    | (ifu.req_pc < BASE_ADDR)
                    | ({1'b0, offset_s} >= SPAN_C);

    // Ready depends only on state and rsp_ready so that a retiring response can overlap the next request.
    assign req_ready_s = rst & ((state_q == S_IDLE) | ((state_q == S_RESP) & ifu.rsp_ready));
    assign accept_s    = ifu.req_valid & req_ready_s;

    assign ifu.req_ready = req_ready_s;
    assign ifu.rsp_valid = rsp_valid_q;
    assign ifu.rsp_instr = instr_q;
    assign ifu.rsp_err   = err_q;
    assign mem_en        = mem_en_q;
    assign mem_addr      = mem_addr_q;

    // Fetch sequencer: state progression plus all registered outputs; a new request overrides the retire path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
            instr_q     <= '0;
            err_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_IDLE;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q    <= S_MEM;
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= addr_q;
                    end
                end
                S_MEM: begin
                    mem_en_q <= 1'b0;
                    state_q  <= S_DATA;
                end
                S_DATA: begin
                    instr_q     <= mem_rdata;
                    err_q       <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (ifu.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                    mem_en_q    <= 1'b0;
                end
            endcase

            if (accept_s) begin
                addr_q <= word_s;
                if (err_s) begin
                    state_q     <= S_RESP;
                    instr_q     <= '0;
                    err_q       <= 1'b1;
                    rsp_valid_q <= 1'b1;
                end else if (LAT_C == 4'd0) begin
                    state_q    <= S_MEM;
                    mem_en_q   <= 1'b1;
                    mem_addr_q <= word_s;
                end else begin
                    state_q <= S_WAIT;
                    cnt_q   <= LAT_C;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifu_imem_responder.sv
// Bench for ifu_imem_responder: two instances (LATENCY 0 and 3) driven in parallel, checked by
// a transaction-timing reference model, a directed vector table and hand-written corner sequences.
module tb_ifu_imem_responder;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          DL2  = 14;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid[2];
    logic [31:0] req_pc[2];
    logic        rsp_ready[2];
    logic        req_ready_o[2];
    logic        rsp_valid_o[2];
    logic        rsp_err_o[2];
    logic [31:0] rsp_instr_o[2];
    logic        mem_en_o[2];
    logic [13:0] mem_addr_o[2];
    logic [31:0] rdata[2];

    int checks   = 0;
    int failures = 0;
    int lat_cfg[2] = '{0, 3};

    always #5 clk = ~clk;

    ifu_imem_responder_if #(.PC_SIZE(32), .INSTR_SIZE(32)) if0 ();
    ifu_imem_responder_if #(.PC_SIZE(32), .INSTR_SIZE(32)) if3 ();

    assign if0.req_valid   = req_valid[0];
    assign if0.req_pc      = req_pc[0];
    assign if0.rsp_ready   = rsp_ready[0];
    assign req_ready_o[0]  = if0.req_ready;
    assign rsp_valid_o[0]  = if0.rsp_valid;
    assign rsp_instr_o[0]  = if0.rsp_instr;
    assign rsp_err_o[0]    = if0.rsp_err;
    assign if3.req_valid   = req_valid[1];
    assign if3.req_pc      = req_pc[1];
    assign if3.rsp_ready   = rsp_ready[1];
    assign req_ready_o[1]  = if3.req_ready;
    assign rsp_valid_o[1]  = if3.rsp_valid;
    assign rsp_instr_o[1]  = if3.rsp_instr;
    assign rsp_err_o[1]    = if3.rsp_err;

    ifu_imem_responder #(.PC_SIZE(32), .INSTR_SIZE(32), .LATENCY(0), .BASE_ADDR(BASE), .DEPTH_LOG2(DL2))
    u_dut0 (.clk(clk), .rst(rst), .ifu(if0), .mem_en(mem_en_o[0]), .mem_addr(mem_addr_o[0]), .mem_rdata(rdata[0]));

    ifu_imem_responder #(.PC_SIZE(32), .INSTR_SIZE(32), .LATENCY(3), .BASE_ADDR(BASE), .DEPTH_LOG2(DL2))
    u_dut3 (.clk(clk), .rst(rst), .ifu(if3), .mem_en(mem_en_o[1]), .mem_addr(mem_addr_o[1]), .mem_rdata(rdata[1]));

    // SRAM contents: word 0 is 32'h0000_0413, every other word a distinct hash of its index.
    function automatic logic [31:0] word_of(input int unsigned a);
        return (a * 32'h9E37_79B9) ^ 32'h0000_0413;
    endfunction

    // Synchronous single-port SRAM per instance.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_en_o[d]) rdata[d] <= word_of({18'd0, mem_addr_o[d]});
        end
    end

    task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %h, expected %h", nm, d, got, exp);
        end
    endtask

    function automatic bit ref_err(input logic [31:0] pc);
        longint p;
        p = pc;
        return (p % 4 != 0) || (p < longint'(BASE)) || (p >= longint'(BASE) + 4 * (longint'(1) << DL2));
    endfunction

    // ---------------- reference model: request timing as plain arithmetic ----------------
    longint      cyc = 0;
    bit          busy[2];
    longint      t_rsp[2];
    longint      t_mem[2];
    bit          m_err[2];
    int unsigned m_addr[2];
    logic [31:0] m_instr[2];
    bit          v_exp[2];
    bit          r_exp[2];
    bit          m_exp[2];

    // Per-cycle comparison of every DUT output against the model, then model update for this cycle's handshakes.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                busy[d] = 1'b0;
            end else begin
                v_exp[d] = busy[d] && (cyc >= t_rsp[d]);
                r_exp[d] = !busy[d] || (v_exp[d] && rsp_ready[d]);
                m_exp[d] = busy[d] && !m_err[d] && (cyc == t_mem[d]);
                chk("req_ready", d, {31'd0, req_ready_o[d]}, {31'd0, r_exp[d]});
                chk("rsp_valid", d, {31'd0, rsp_valid_o[d]}, {31'd0, v_exp[d]});
                chk("mem_en", d, {31'd0, mem_en_o[d]}, {31'd0, m_exp[d]});
                if (v_exp[d]) begin
                    chk("rsp_instr", d, rsp_instr_o[d], m_instr[d]);
                    chk("rsp_err", d, {31'd0, rsp_err_o[d]}, {31'd0, m_err[d]});
                end
                if (m_exp[d]) chk("mem_addr", d, {18'd0, mem_addr_o[d]}, m_addr[d]);
                if (v_exp[d] && rsp_ready[d]) busy[d] = 1'b0;
                if (req_valid[d] && r_exp[d]) begin
                    busy[d]  = 1'b1;
                    m_err[d] = ref_err(req_pc[d]);
                    m_addr[d] = (req_pc[d] - BASE) / 4;
                    m_instr[d] = m_err[d] ? 32'd0 : word_of(m_addr[d]);
                    t_rsp[d] = cyc + (m_err[d] ? 1 : lat_cfg[d] + 3);
                    t_mem[d] = cyc + lat_cfg[d] + 1;
                end
            end
        end
        cyc++;
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] pc;
        int          bp;
        bit          err;
        int unsigned addr;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input vec_t v);
        bit          acc[2];
        bit          done[2];
        int          acc_k[2];
        int          lat[2];
        int          stall[2];
        logic [31:0] g_instr[2];
        logic        g_err[2];
        for (int d = 0; d < 2; d++) begin
            lat[d]       = -1;
            req_valid[d] = 1'b1;
            req_pc[d]    = v.pc;
            rsp_ready[d] = (v.bp == 0);
        end
        for (int k = 0; k < 80 && !(done[0] && done[1]); k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!acc[d]) begin
                    if (req_ready_o[d]) begin
                        acc[d]   = 1'b1;
                        acc_k[d] = k;
                    end
                end else if (!done[d] && rsp_valid_o[d]) begin
                    if (lat[d] < 0) lat[d] = k - acc_k[d];
                    if (rsp_ready[d]) begin
                        done[d]    = 1'b1;
                        g_instr[d] = rsp_instr_o[d];
                        g_err[d]   = rsp_err_o[d];
                    end else begin
                        stall[d]++;
                    end
                end
            end
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (acc[d]) req_valid[d] = 1'b0;
                rsp_ready[d] = (stall[d] >= v.bp);
            end
        end
        for (int d = 0; d < 2; d++) begin
            chk("vec_done", d, {31'd0, done[d]}, 32'd1);
            if (done[d]) begin
                chk("vec_instr", d, g_instr[d], v.err ? 32'd0 : word_of(v.addr));
                chk("vec_err", d, {31'd0, g_err[d]}, {31'd0, v.err});
                chk("vec_latency", d, lat[d], v.err ? 1 : lat_cfg[d] + 3);
            end
        end
    endtask

    task automatic run_b2b();
        int nacc[2];
        int nrsp[2];
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b1;
            req_pc[d]    = BASE;
            rsp_ready[d] = 1'b1;
        end
        for (int k = 0; k < 100 && !(nrsp[0] == 3 && nrsp[1] == 3); k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rsp_valid_o[d] && nrsp[d] < 3) begin
                    chk("b2b_instr", d, rsp_instr_o[d], word_of(nrsp[d]));
                    if (nrsp[d] < 2) chk("b2b_overlap", d, {31'd0, req_ready_o[d] & req_valid[d]}, 32'd1);
                    nrsp[d]++;
                end
                if (req_valid[d] && req_ready_o[d]) nacc[d]++;
            end
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                req_valid[d] = (nacc[d] < 3);
                req_pc[d]    = BASE + 32'(4 * nacc[d]);
            end
        end
        for (int d = 0; d < 2; d++) chk("b2b_count", d, nrsp[d], 32'd3);
    endtask

    task automatic chk_reset(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_req_ready"}, d, {31'd0, req_ready_o[d]}, 32'd0);
            chk({tag, "_rsp_valid"}, d, {31'd0, rsp_valid_o[d]}, 32'd0);
            chk({tag, "_rsp_instr"}, d, rsp_instr_o[d], 32'd0);
            chk({tag, "_rsp_err"}, d, {31'd0, rsp_err_o[d]}, 32'd0);
            chk({tag, "_mem_en"}, d, {31'd0, mem_en_o[d]}, 32'd0);
            chk({tag, "_mem_addr"}, d, {18'd0, mem_addr_o[d]}, 32'd0);
        end
    endtask

    // Accept one request, let it advance wait_cycles edges, then pull reset between clock edges.
    task automatic run_reset_mid(input int wait_cycles, input string tag);
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b1;
            req_pc[d]    = BASE + 32'h20;
            rsp_ready[d] = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) req_valid[d] = 1'b0;
        repeat (wait_cycles) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_reset(tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) rsp_ready[d] = 1'b1;
        run_vec('{32'h8000_0040, 0, 1'b0, 16});
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        case ($urandom_range(0, 5))
            0, 1:    p = BASE + 32'(4 * $urandom_range(0, 16383));
            2:       p = BASE + 32'($urandom_range(0, 65535));
            3:       p = $urandom;
            4:       p = BASE + 32'h0001_0000 - 32'(4 * $urandom_range(0, 1));
            5:       p = BASE - 32'(4 * $urandom_range(1, 4));
            default: p = BASE;
        endcase
        return p;
    endfunction

    initial begin
        vecs[0] = '{32'h8000_0000, 0, 1'b0, 0};
        vecs[1] = '{32'h8000_0010, 0, 1'b0, 4};
        vecs[2] = '{32'h8000_0002, 0, 1'b1, 0};
        vecs[3] = '{32'h7FFF_FFFC, 0, 1'b1, 0};
        vecs[4] = '{32'h8001_0000, 0, 1'b1, 0};
        vecs[5] = '{32'h8000_FFFC, 0, 1'b0, 16383};
        vecs[6] = '{32'h8000_0004, 5, 1'b0, 1};
        vecs[7] = '{32'h0000_0000, 5, 1'b1, 0};
        vecs[8] = '{32'hFFFF_FFFC, 0, 1'b1, 0};
        vecs[9] = '{32'h8000_0101, 0, 1'b1, 0};

        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_pc[d]    = 32'd0;
            rsp_ready[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_reset("por");
        rst = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);
        run_b2b();
        run_reset_mid(1, "rst_wait");
        run_reset_mid(6, "rst_resp");

        repeat (1500) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                req_valid[d] = ($urandom_range(0, 99) < 60);
                rsp_ready[d] = ($urandom_range(0, 99) < 70);
                req_pc[d]    = rand_pc();
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            rsp_ready[d] = 1'b1;
        end
        repeat (10) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifu_imem_responder.md
Name: ifu_imem_responder

Overview:
Responder end of the IFetch REQ/RSP channel. It accepts fetch requests (ifu_req_valid/ready, ifu_req_pc) from the fetch unit and reads one 32-bit word from a synchronous single-port instruction SRAM, after a configurable wait. It returns the word on the RSP channel (ifu_rsp_valid/ready, ifu_rsp_instr) and flags misaligned or out-of-range fetches. It sits between ifu_ifetch and the instruction SRAM macro, with at most one request outstanding.

Parameters:
PC_SIZE, 32, request address width
INSTR_SIZE, 32, instruction/data width
LATENCY, 0, extra wait cycles inserted before the SRAM access (0..15)
BASE_ADDR, 32'h8000_0000, byte address of SRAM word 0
DEPTH_LOG2, 14, log2 of SRAM depth in words

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-low
ifu_req_valid  input  1  fetch request valid
ifu_req_ready  output  1  responder can accept a request
ifu_req_pc  input  PC_SIZE  fetch byte address
ifu_rsp_valid  output  1  response valid
ifu_rsp_ready  input  1  fetch unit accepts the response
ifu_rsp_instr  output  INSTR_SIZE  fetched instruction
ifu_rsp_err  output  1  access fault for this response
mem_en  output  1  SRAM read enable
mem_addr  output  DEPTH_LOG2  SRAM word address
mem_rdata  input  INSTR_SIZE  SRAM read data, valid in the cycle after mem_en

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, wait counter=0, latched pc=0
  - ifu_rsp_valid=0, ifu_rsp_instr=0, ifu_rsp_err=0, mem_en=0, mem_addr=0
  - ifu_req_ready forced 0 while rst is low
  - Reset mid-transaction aborts it with no response.
- Handshakes:
  - req handshake = ifu_req_valid & ifu_req_ready
  - rsp handshake = ifu_rsp_valid & ifu_rsp_ready
- Fault check, performed on ifu_req_pc in the req handshake cycle. err=1 if any of:
  - pc[1:0]!=0
  - pc<BASE_ADDR
  - pc-BASE_ADDR >= 4<<DEPTH_LOG2
  - The subtraction is unsigned PC_SIZE-bit.
- Word address: (pc-BASE_ADDR)[DEPTH_LOG2+1:2].
- State IDLE: ifu_req_ready=1. On req handshake, latch pc, then:
  - err -> RESP, with instr register=0 and ifu_rsp_err=1
  - else LATENCY==0 -> MEM
  - else -> WAIT, counter=LATENCY
- State WAIT: ifu_req_ready=0; counter decrements each cycle; when counter==1 -> MEM.
- State MEM: ifu_req_ready=0; mem_en=1; mem_addr=latched word address; -> DATA.
- State DATA: ifu_req_ready=0; mem_en=0; mem_rdata is captured into the instr register at the end of the cycle with err=0; -> RESP.
- State RESP:
  - ifu_rsp_valid=1; ifu_rsp_instr and ifu_rsp_err are held stable until the rsp handshake.
  - ifu_req_ready = ifu_rsp_ready.
  - rsp handshake without new req -> IDLE.
  - rsp handshake with simultaneous req handshake -> the new request is processed exactly as the IDLE transition (fault check, latch), no bubble. This case is mandatory: ifu_ifetch issues its next request in the same cycle the response retires.
  - ifu_rsp_ready=0 -> stay in RESP; no request is accepted.
- Latency, req handshake to first ifu_rsp_valid:
  - normal access: LATENCY+3 cycles
  - fault: 1 cycle
- mem_en is asserted for exactly one cycle per non-fault request; never for faults.
- ifu_rsp_valid is never asserted without a preceding accepted request; exactly one response per accepted request.
- ifu_req_ready and ifu_rsp_valid must not depend combinationally on ifu_req_valid.

Test Plan:
- LATENCY=0, req pc=32'h8000_0000, SRAM word0=32'h0000_0413, ifu_rsp_ready=1 -> mem_en pulse with mem_addr=0 one cycle after handshake; ifu_rsp_valid 3 cycles after handshake with instr=32'h0000_0413, err=0.
- LATENCY=3, pc=32'h8000_0010 -> mem_addr=4; ifu_rsp_valid at handshake+6; ifu_req_ready=0 throughout WAIT/MEM/DATA.
- pc=32'h8000_0002, then pc=32'h7FFF_FFFC, then pc=32'h8001_0000 (DEPTH_LOG2=14) -> each gives ifu_rsp_valid at handshake+1 with err=1, instr=0, and no mem_en.
- Back-to-back: hold ifu_req_valid=1 with pc=0x8000_0000, 0x8000_0004, 0x8000_0008, ifu_rsp_ready=1 -> each request is accepted in the same cycle the previous response retires; three responses in order with the correct words.
- Backpressure: ifu_rsp_ready=0 for 5 cycles in RESP -> instr/err stable, ifu_req_ready=0, no second mem_en; release -> single handshake.
- Assert rst in WAIT and in RESP -> outputs reach their reset values without waiting for a clock edge; first request after release is served normally.
